// File: rtl/text_pixel_engine.sv
// text_pixel_engine: 640x480@60 text-mode pixel pipeline.
// Stage 0 walks the raster and issues character-RAM reads. Stage 1 takes the
// character word and issues the font-ROM lookup. Stage 2 picks the glyph bit
// and registers the colour. Syncs and de travel through the same stages, so
// every output lags the raster counters by exactly 3 clocks.
//
// Memory read protocol, used by both the character RAM and the font ROM:
// the address (and vram_en for the RAM) is presented during cycle k. The
// memory samples it on the closing edge of cycle k. Data is valid throughout
// cycle k+1. There is no backpressure and no ready signal.
module text_pixel_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int COLS         = 80,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        vram_en,
  output logic [11:0] vram_addr,
  input  logic [15:0] vram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [11:0] cursor_addr,
  input  logic        cursor_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [3:0]  pix_color
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // The cell address is built as (row<<6)+(row<<4)+col, which is row*80+col.
  // This only works for an 80-column buffer.
  if (COLS != 80) begin : g_cols_check
    $error("text_pixel_engine: address shift-add assumes COLS == 80");
  end

  // Raster and blink state.
  logic          r_run;
  logic [9:0]    r_hc;
  logic [9:0]    r_vc;
  logic [BW-1:0] r_frame;
  logic          r_phase;
  logic [11:0]   r_addr_hold;

  // Stage 1 registers.
  logic          r_de1, r_hs1, r_vs1;
  logic [2:0]    r_hx1;
  logic [3:0]    r_gr1;
  logic [11:0]   r_cell1;

  // Stage 2 registers.
  logic          r_de2, r_hs2, r_vs2, r_hit2;
  logic [2:0]    r_hx2;
  logic [3:0]    r_fg2, r_bg2;

  // Stage 0 combinational terms.
  logic          w_h_last, w_v_last;
  logic          w_de0, w_hs0, w_vs0;
  logic [4:0]    w_row;
  logic [6:0]    w_col;
  logic [11:0]   w_cell;

  // Stage 1 and stage 2 combinational terms.
  logic          w_hit;
  logic          w_bit;

  assign w_h_last = (r_hc == 10'(H_TOTAL - 1));
  assign w_v_last = (r_vc == 10'(V_TOTAL - 1));
  // r_run is low for one clock after reset, so the raster starts cleanly at (0,0).
  assign w_de0    = r_run && (r_hc < 10'(H_ACTIVE)) && (r_vc < 10'(V_ACTIVE));
  assign w_hs0    = !((r_hc >= 10'(HS_FIRST)) && (r_hc <= 10'(HS_LAST)));
  assign w_vs0    = !((r_vc >= 10'(VS_FIRST)) && (r_vc <= 10'(VS_LAST)));
  assign w_row    = r_vc[8:4];
  assign w_col    = r_hc[9:3];
  assign w_cell   = {1'b0, w_row, 6'b0} + {3'b0, w_row, 4'b0} + {5'b0, w_col};

  // During blanking no read is issued and the address holds its last value.
  assign vram_en   = w_de0;
  assign vram_addr = w_de0 ? w_cell : r_addr_hold;

  assign font_addr = r_de1 ? {vram_data[7:0], r_gr1} : 12'd0;
  // The underline occupies glyph rows 14 and 15, and only while the blink phase is high.
  assign w_hit     = cursor_en && (r_cell1 == cursor_addr) && (r_gr1 >= 4'd14) && r_phase;
  assign w_bit     = font_data[3'd7 - r_hx2] | r_hit2;

  // Raster counters. They hold at (0,0) until the first clock after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run <= 1'b0;
      r_hc  <= '0;
      r_vc  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_h_last) begin
          r_hc <= '0;
          r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  // Frame counter. The blink phase toggles every BLINK_FRAMES frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (r_run && w_h_last && w_v_last) begin
      if (r_frame == BW'(BLINK_FRAMES - 1)) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  // Stage 0 to stage 1: cell address, glyph coordinates and timing flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hold <= '0;
      r_de1       <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      r_hx1       <= '0;
      r_gr1       <= '0;
      r_cell1     <= '0;
    end else begin
      if (w_de0) r_addr_hold <= w_cell;
      r_de1   <= w_de0;
      r_hs1   <= w_hs0;
      r_vs1   <= w_vs0;
      r_hx1   <= r_hc[2:0];
      r_gr1   <= r_vc[3:0];
      r_cell1 <= w_cell;
    end
  end

  // Stage 1 to stage 2: latch the colours and the cursor hit while the font lookup runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de2  <= 1'b0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_hit2 <= 1'b0;
      r_hx2  <= '0;
      r_fg2  <= '0;
      r_bg2  <= '0;
    end else begin
      r_de2  <= r_de1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_hit2 <= w_hit;
      r_hx2  <= r_hx1;
      r_fg2  <= vram_data[11:8];
      r_bg2  <= vram_data[15:12];
    end
  end

  // Output register: colour select, with the colour forced to 0 outside the visible area.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      de        <= 1'b0;
      pix_color <= '0;
    end else begin
      hsync     <= r_hs2;
      vsync     <= r_vs2;
      de        <= r_de2;
      pix_color <= r_de2 ? (w_bit ? r_fg2 : r_bg2) : 4'd0;
    end
  end

endmodule

// File: tb/tb_text_pixel_engine.sv
// Bench for text_pixel_engine using a reduced raster geometry.
// Line layout: 64 + 4 + 8 + 4 = 80 clocks.
// Frame layout: 32 + 2 + 2 + 2 = 38 lines.
// Blink half-period: 2 frames.
// The whole bench runs in a few tens of thousands of clocks.
module tb_text_pixel_engine;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 32, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BL = 2;

  logic        clk;
  logic        rst;
  logic        vram_en;
  logic [11:0] vram_addr;
  logic [15:0] vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] cursor_addr;
  logic        cursor_en;
  logic        hsync, vsync, de;
  logic [3:0]  pix_color;

  logic [15:0] mem [0:2399];
  logic [7:0]  rom [0:4095];

  int n;
  int checks;
  int errors;
  int last_addr;
  bit checking;
  int line0_exp [0:7];

  text_pixel_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLS(80), .BLINK_FRAMES(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vram_en(vram_en),
    .vram_addr(vram_addr),
    .vram_data(vram_data),
    .font_addr(font_addr),
    .font_data(font_data),
    .cursor_addr(cursor_addr),
    .cursor_en(cursor_en),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .pix_color(pix_color)
  );

  // Clock and edge counter.
  // n counts rising edges since reset release.
  // In the cycle after edge n, stage 0 is at raster position n-1 and the outputs show position n-4.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // Memory models with a synchronous read.
  always @(posedge clk) begin
    if (vram_en && vram_addr < 12'd2400) vram_data <= mem[vram_addr];
    font_data <= rom[font_addr];
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0d exp=%0d", name, n, got, exp);
    end
  endtask

  // Reference model, expressed as raster arithmetic on position q.
  function automatic bit vis(input int q);
    int hc, vc;
    hc = q % HT;
    vc = (q / HT) % VT;
    return (hc < HA) && (vc < VA);
  endfunction

  function automatic int cell_of(input int q);
    int hc, vc;
    hc = q % HT;
    vc = (q / HT) % VT;
    return (vc / 16) * 80 + hc / 8;
  endfunction

  function automatic int exp_pix(input int q);
    int hc, vc, fr, c, w, g, b;
    hc = q % HT;
    vc = (q / HT) % VT;
    fr = q / FT;
    if (!vis(q)) return 0;
    c = cell_of(q);
    w = int'(mem[c]);
    g = int'(rom[(w & 255) * 16 + vc % 16]);
    b = (g >> (7 - hc % 8)) & 1;
    if (cursor_en && c == int'(cursor_addr) && (vc % 16) >= 14 && ((fr / BL) % 2) == 1) b = 1;
    return (b != 0) ? ((w >> 8) & 15) : ((w >> 12) & 15);
  endfunction

  // Compare process: every cycle, plus literal pins on the model.
  always @(negedge clk) begin
    int p, q, hc, vc, exp_en, exp_addr;
    if (checking) begin
      if (n == 0) last_addr = 0;
      p = n - 1;
      exp_en   = (n >= 1 && vis(p)) ? 1 : 0;
      exp_addr = (exp_en != 0) ? cell_of(p) : last_addr;
      check("vram_en", int'(vram_en), exp_en);
      check("vram_addr", int'(vram_addr), exp_addr);
      if (exp_en != 0) last_addr = exp_addr;

      q = n - 4;
      if (q >= 0) begin
        hc = q % HT;
        vc = (q / HT) % VT;
        check("hsync", int'(hsync), (hc >= HA + HF && hc < HA + HF + HS) ? 0 : 1);
        check("vsync", int'(vsync), (vc >= VA + VF && vc < VA + VF + VS) ? 0 : 1);
        check("de", int'(de), vis(q) ? 1 : 0);
        check("pix_color", int'(pix_color), exp_pix(q));
      end else begin
        check("hsync_idle", int'(hsync), 1);
        check("vsync_idle", int'(vsync), 1);
        check("de_idle", int'(de), 0);
        check("pix_idle", int'(pix_color), 0);
      end

      // Literal pins, computed by hand.
      if (n == 1 + 8)       check("lit_addr_col1", int'(vram_addr), 1);
      if (n == 1 + 16 * HT) check("lit_addr_row1", int'(vram_addr), 80);
      if (n == 1 + HA)      check("lit_en_hblank", int'(vram_en), 0);
      if (n == 3)           check("lit_de_before", int'(de), 0);
      if (n == 4)           check("lit_de_first", int'(de), 1);
      if (q >= 0 && q < 8)  check("lit_line0_px", int'(pix_color), line0_exp[q]);
      if (n == HA + HF + 3) check("lit_hsync_pre", int'(hsync), 1);
      if (n == HA + HF + 4) check("lit_hsync_fall", int'(hsync), 0);
      if (q == 14 * HT)                check("lit_cursor_off_f0", int'(pix_color), 1);
      if (q == 2 * FT + 14 * HT)       check("lit_cursor_on_f2", int'(pix_color), 14);
      if (q == 3 * FT + 15 * HT + 1)   check("lit_cursor_on_f3", int'(pix_color), 14);
      if (q == 6 * FT + 14 * HT)       check("lit_cursor_dis_f6", int'(pix_color), 1);
    end
  end

  // Watchdog.
  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog n=%0d got=running exp=finished", n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int target, r;
    checks = 0;
    errors = 0;
    last_addr = 0;
    checking = 1'b0;
    line0_exp[0] = 14; line0_exp[1] = 1; line0_exp[2] = 1; line0_exp[3] = 1;
    line0_exp[4] = 1;  line0_exp[5] = 1; line0_exp[6] = 1; line0_exp[7] = 14;
    rst = 1'b1;
    cursor_en = 1'b1;
    cursor_addr = 12'd0;
    vram_data = 16'd0;
    font_data = 8'd0;
    for (int i = 0; i < 2400; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
    mem[0] = 16'h1E41;
    for (int r2 = 0; r2 < 16; r2++) rom[8'h41 * 16 + r2] = 8'h00;
    rom[8'h41 * 16] = 8'h81;

    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Eight frames. In each frame's vertical blanking, reload the RAM and set up the next frame's cursor.
    for (int f = 0; f < 8; f++) begin
      target = f * FT + (VA + 1) * HT + 1;
      while (n < target) @(negedge clk);
      for (int i = 1; i < 2400; i++) mem[i] = 16'($urandom);
      case (f + 1)
        4: begin cursor_en = 1'b1; cursor_addr = 12'($urandom_range(0, 87)); end
        5: begin cursor_en = 1'b0; cursor_addr = 12'd0; end
        6: begin cursor_en = 1'b1; cursor_addr = 12'd2400; end
        7: begin
          r = $urandom_range(0, 15);
          cursor_en = 1'b1;
          cursor_addr = 12'((r < 8) ? r : 72 + r);
        end
        default: begin cursor_en = 1'b1; cursor_addr = 12'd0; end
      endcase
    end

    // Reset mid-line at hc=30, vc=10 of frame 8.
    target = 8 * FT + 10 * HT + 30 + 1;
    while (n < target - 1) @(negedge clk);
    @(posedge clk);
    #2;
    checking = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_de", int'(de), 0);
    check("rst_pix", int'(pix_color), 0);
    check("rst_vram_en", int'(vram_en), 0);
    check("rst_vram_addr", int'(vram_addr), 0);
    check("rst_font_addr", int'(font_addr), 0);
    cursor_en = 1'b1;
    cursor_addr = 12'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    while (n < FT + 4 * HT) @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_pixel_engine.md
Name: text_pixel_engine

Overview:
- Video-side consumer of the dual-clock character RAM; runs in the pixel-clock domain and drives that RAM's read port.
- Generates 640x480@60 timing and fetches one 16-bit character word per pixel from the 80x30 text buffer (2400 words).
- Looks up the 8x16 glyph row in an external font ROM and emits a 4-bit colour index with aligned syncs and data-enable.
- Overlays a blinking underline cursor.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- COLS, 80, characters per text row
- BLINK_FRAMES, 32, frames per cursor blink half-period

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal); also clocks the RAM read port
- rst  in  1  asynchronous reset, active-high
- vram_en  out  1  RAM read enable
- vram_addr  out  12  RAM read address, row*COLS+col, range 0..2399
- vram_data  in  16  RAM read data; valid 1 clk after vram_en; [7:0] char code, [11:8] fg, [15:12] bg
- font_addr  out  12  {char[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row; valid 1 clk after font_addr; bit7 = leftmost pixel
- cursor_addr  in  12  cell index of cursor; >=2400 disables the cursor
- cursor_en  in  1  cursor overlay enable
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- de  out  1  data enable, high for visible pixels
- pix_color  out  4  colour index; 0 when de=0

Behaviour:
- Reset (async): hc=vc=0, blink counter=0, blink phase=0, all pipeline registers cleared. Outputs: hsync=1, vsync=1, de=0, pix_color=0, vram_en=0, vram_addr=0, font_addr=0. Deassertion is clean; the first clk after release starts the frame at hc=vc=0.
- Counters: hc counts 0..799 and wraps to 0. vc increments when hc wraps and itself wraps 524->0. Constants are sums of the parameters.
- Sync and enable, computed at stage 0:
  - hsync_n low for hc in [656,751].
  - vsync_n low for vc in [490,491].
  - de0 = (hc<640)&&(vc<480).
- S0:
  - vram_en=de0.
  - vram_addr = vc[8:4]*80 + hc[9:3], formed as shift-add (row<<6)+(row<<4)+col; 12-bit result.
  - Register hc[2:0], vc[3:0], cell index, de0 and syncs.
- S1 (vram_data valid):
  - font_addr={vram_data[7:0], vc_d1[3:0]}.
  - Latch fg/bg.
  - cursor_hit = cursor_en && cell_d1==cursor_addr && vc_d1[3:0]>=14 && blink_phase.
- S2 (font_data valid):
  - bit = font_data[7-hc_d2[2:0]] | cursor_hit_d2.
  - Register the output: pix_color = de_d2 ? (bit ? fg : bg) : 0.
- Latency:
  - hsync, vsync, de and pix_color are all delayed 3 clks from the counter values.
  - Counter state (hc,vc)=(0,0) appears on outputs at the 3rd rising edge after it is generated.
  - hsync, vsync and de remain mutually aligned.
- Blink:
  - A frame counter increments at the tick where vc wraps 524->0.
  - On reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
  - Blink period = 2*BLINK_FRAMES frames.
- Boundaries:
  - Last visible cell (row 29, col 79) gives vram_addr=2399.
  - No read is issued during blanking; vram_addr holds its last value while vram_en=0.
  - A cursor_addr change takes effect on the next fetched cell, with no frame alignment.
  - Reset mid-frame returns everything to the reset state immediately; the frame restarts with no partial-line glitch after release.

Test Plan:
- Timing: run 2 frames from reset -> hsync low for 96 clks every 800; vsync low for exactly 2 lines (1600 clks) every 420000 clks; de high for 640 clks per line on 480 lines per frame.
- Addressing: monitor vram_en/vram_addr -> at (hc=8,vc=0) addr=1; at (hc=0,vc=16) addr=80; at (hc=639,vc=479) addr=2399; vram_en=0 at (hc=640,vc=0).
- Pixel path:
  - Setup: RAM model with cell0=0x1E41; font ROM with row0 of 'A' = 0x81.
  - Required: first 8 visible pixels of line 0 = 14,1,1,1,1,1,1,14.
  - Required: the first pixel appears 3 clks after (0,0) with de=1.
- Cursor:
  - Setup: cursor_addr=0, cursor_en=1, blank glyph, attr 0x2000 (bg=2, fg=0).
  - Required: lines 14-15 of cell 0 show 0 in frames 32-63, and 2 in frames 0-31.
  - Required: cursor_addr=2400 gives no overlay.
- Reset mid-line: assert rst at hc=300, vc=100 -> outputs return to reset values within the same clk. After release, hc/vc restart at 0 and the first hsync falls 656+3 clks later.
